// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// Frame on sout: start bit (0), WIDTH data bits LSB first, optional parity bit, stop bit (1).
// The line idles high. sout/busy/done come straight from flops, so they cannot glitch.
// Optional feature macro: TX_PARITY_EN inserts a parity bit (even, or odd when PARITY_ODD=1)
// between the last data bit and the stop bit. Without it the frame has no parity bit.
module serial_frame_tx #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             sout_nxt, busy_nxt, done_nxt;
    logic             xfer;

`ifdef TX_PARITY_EN
    logic par_q, par_nxt;
`endif

    // A word can be accepted while idle or while the stop bit is going out.
    assign load_ready = (state == IDLE) || (state == STOP);
    assign xfer       = load_valid && load_ready;

    // Next-state, next-datapath and next-output decode.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
`ifdef TX_PARITY_EN
        par_nxt   = par_q;
`endif
        case (state)
            IDLE, STOP: begin
                if (xfer) begin
                    state_nxt = START;
                    shreg_nxt = data_in;
                    cnt_nxt   = '0;
`ifdef TX_PARITY_EN
                    // Parity is taken from the word as it is latched.
                    par_nxt   = (^data_in) ^ PARITY_ODD;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
            end
            DATA: begin
                shreg_nxt = shreg >> 1;
                if (cnt == CW'(WIDTH - 1)) begin
`ifdef TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                state_nxt = STOP;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the upcoming state.
        // In DATA the bit on the line is always bit 0 of the (next) shift register.
        sout_nxt = 1'b1;
        case (state_nxt)
            START:   sout_nxt = 1'b0;
            DATA:    sout_nxt = shreg_nxt[0];
`ifdef TX_PARITY_EN
            PARITY:  sout_nxt = par_nxt;
`endif
            default: sout_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == STOP);
    end

    // State, datapath and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            sout  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            sout  <= sout_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
`ifdef TX_PARITY_EN
            par_q <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench for serial_frame_tx (WIDTH=8, PARITY_ODD=0).
// Stimulus pushes the hand-computed line sequence of each accepted frame into a queue;
// a monitor on the falling edge pops one entry per busy cycle and checks idle otherwise.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] data_in;
    logic       load_ready;
    logic       sout;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic sout;
        logic done;
        logic ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    serial_frame_tx #(.WIDTH(8), .PARITY_ODD(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .data_in    (data_in),
        .load_ready (load_ready),
        .sout       (sout),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Monitor: one comparison per cycle, frame bit while expected, idle line otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (!(busy === 1'b1 && sout === e.sout && done === e.done && load_ready === e.ready)) begin
                    errors++;
                    $display("FAIL frame_bit t=%0t: got sout=%b busy=%b done=%b ready=%b, want sout=%b busy=1 done=%b ready=%b",
                             $time, sout, busy, done, load_ready, e.sout, e.done, e.ready);
                end
            end else begin
                if (!(busy === 1'b0 && sout === 1'b1 && done === 1'b0 && load_ready === 1'b1)) begin
                    errors++;
                    $display("FAIL idle_line t=%0t: got sout=%b busy=%b done=%b ready=%b, want sout=1 busy=0 done=0 ready=1",
                             $time, sout, busy, done, load_ready);
                end
            end
        end
    end

    // Push a frame's line sequence, given in time order from the MSB of seq downward.
    task automatic expect_frame(input logic [15:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.sout  = seq[n-1-i];
            e.done  = (i == n - 1);
            e.ready = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Offer a word and wait (bounded) for the transfer edge; then record the expected frame.
    task automatic send(input logic [7:0] word, input logic [15:0] seq_np,
                        input logic [15:0] seq_p, input bit keep_valid);
        bit rdy;
        bit ok = 1'b0;
        load_valid = 1'b1;
        data_in    = word;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            rdy = load_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
`ifdef TX_PARITY_EN
            expect_frame(seq_p, 11);
`else
            expect_frame(seq_np, 10);
`endif
        end else begin
            checks++;
            errors++;
            $display("FAIL load_timeout: load_ready never seen, want 1");
        end
        #1;
        if (!keep_valid) load_valid = 1'b0;
    endtask

    // Wait (bounded) for every expected frame bit to be consumed and the line idle.
    task automatic drain();
        bit ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: queue=%0d busy=%b, want 0 and 0", exp_q.size(), busy);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1/2: 0xA5 -> 0,10100101,[0],1
        send(8'hA5, 16'b0101001011, 16'b01010010101, 1'b0);
        drain();
        // 2: 0x07 -> 0,11100000,[1],1
        send(8'h07, 16'b0111000001, 16'b01110000011, 1'b0);
        drain();

        // 3: 0x00 then 0xFF held; second transfer lands in the stop cycle.
        send(8'h00, 16'b0000000001, 16'b00000000001, 1'b1);
        data_in = 8'hFF;
        send(8'hFF, 16'b0111111111, 16'b01111111101, 1'b0);
        drain();

        // 4: 0x3C, with a 0x55 pulse in DATA that must be ignored.
        send(8'h3C, 16'b0001111001, 16'b00011110001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        load_valid = 1'b1;
        data_in    = 8'h55;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        drain();

        // 5: 0xFF, reset mid DATA abandons the frame; next load 0x5A transmits.
        send(8'hFF, 16'b0111111111, 16'b01111111101, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        exp_q.delete();
        #1;
        reset = 1'b0;
        send(8'h5A, 16'b0010110101, 16'b00101101001, 1'b0);
        drain();

        // 6: reset held with load_valid for 3 cycles -> no transfer, line stays idle.
        reset      = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hC3;
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b0;
        load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
